proc_io_sched: RTL and testbench
================================

# proc_io_sched

Sample-stream scheduler between the ADC-side stream and a filter `processor` instance. It buffers incoming samples in a FIFO and holds the processor in reset until a prefill threshold is met. It serves the processor's `req_in` reads from the FIFO head, recovers from underflow by re-priming, and converts decoded `out_en` strobes into a tagged output stream.

## Interface
Parameters:
- NUBITS, 32, sample/word width
- NOUT, 7, width of decoded processor output-enable bus
- NBCH, 3, width of output channel index (>= clog2(NOUT))
- FDEPTH, 16, input FIFO depth, power of 2
- NBFIFO, 4, log2(FDEPTH)
- PRIME, 4, FIFO occupancy required to release processor (1..FDEPTH)
- RSTLEN, 4, processor reset pulse length on fault, cycles (>=1)

Ports:
- clk  in  1  clock; one clock domain
- rst  in  1  synchronous, active-high reset
- s_data  in  NUBITS  input sample
- s_valid  in  1  s_data valid
- s_ready  out  1  FIFO can accept
- proc_in  out  NUBITS  FIFO head, drives processor `in`
- proc_req_in  in  1  processor input read strobe
- proc_rst  out  1  reset to processor, active-high
- proc_out  in  NUBITS  processor `out`
- proc_out_en  in  NOUT  decoded output enables (addr_dec output)
- m_data  out  NUBITS  captured output word
- m_chan  out  NBCH  index of asserted out_en bit
- m_valid  out  1  one-cycle strobe, no backpressure
- err_clr  in  1  clears sticky flags
- underflow  out  1  sticky: read on empty FIFO in RUN
- collision  out  1  sticky: more than one out_en bit high
- running  out  1  state == RUN
- in_cnt, out_cnt, uf_cnt  out  16 each  statistics (see Configuration)

## Operation
- FIFO: register array, wr/rd pointers NBFIFO bits, wrap modulo FDEPTH, count NBFIFO+1 bits. s_ready = !full && state != FAULT. Push on s_valid && s_ready. proc_in = mem[rd_ptr] combinationally, 0 when empty.
- Pop only on proc_req_in && state==RUN && !empty. Push and pop in same cycle: count unchanged. Push into empty FIFO is not bypassed to a same-cycle pop; that read is an underflow.
- FSM states PRIME, RUN, FAULT:
  - PRIME: proc_rst=1, proc_req_in ignored; count >= PRIME -> RUN.
  - RUN: proc_rst=0; proc_req_in && empty -> FAULT, underflow<=1.
  - FAULT: proc_rst=1; FIFO flushed (pointers, count to 0) on entry cycle; counter runs RSTLEN cycles, then -> PRIME. Incoming samples refused.
- Output capture (any state): if proc_out_en != 0, next cycle m_valid=1, m_data=proc_out, m_chan = index of lowest set bit. If >1 bit set, collision<=1 (lowest index still emitted). m_data/m_chan hold between strobes.
- err_clr clears underflow and collision; a same-cycle set wins over clear.

## Timing
- Reset values: state PRIME, FIFO empty, proc_rst=1, s_ready=1, proc_in=0, m_valid=0, m_data=0, m_chan=0, underflow=0, collision=0, running=0, all counters 0.
- proc_rst, running, m_* and flags are registered. proc_rst falls in the first cycle after the cycle in which count reached PRIME.
- Output latency: proc_out_en high at cycle n -> m_valid high at n+1, exactly one cycle per strobe cycle.
- Underflow at n -> proc_rst=1 from n+1 for RSTLEN cycles (FAULT), PRIME from n+1+RSTLEN.
- rst mid-operation discards FIFO contents and returns to reset values next cycle.

## Configuration
- IO_SCHED_STATS_EN defined: in_cnt increments per push, out_cnt per m_valid, uf_cnt per underflow event. All counters saturate at 16'hFFFF and clear on rst only.
- Not defined: counters not built, in_cnt/out_cnt/uf_cnt tied to 0. All other behaviour identical.

## Test plan
- Prime: rst, push 3 samples -> proc_rst stays 1; 4th push -> proc_rst=0 and running=1 one cycle later; proc_in shows first sample.
- Steady stream: push 100 ramp samples at 1/2 rate, processor reads 1/4 rate -> reads return 0,1,2,... in order; s_ready drops after 16 unread samples and FIFO never exceeds FDEPTH.
- Underflow: in RUN with FIFO empty, pulse proc_req_in -> underflow=1, proc_rst high exactly 4 cycles, s_ready=0 meanwhile, then PRIME with count 0.
- Output tagging: proc_out_en=7'b0000100, proc_out=32'h3F800000 -> next cycle m_valid=1, m_chan=2, m_data=32'h3F800000; proc_out_en=7'b0010010 -> m_chan=1, collision=1; err_clr -> collision=0.
- Simultaneous push/pop at count 5 -> count stays 5; push into empty with same-cycle read -> underflow.
- Stats (macro on): 20 pushes, 7 outputs, 1 underflow -> in_cnt=20, out_cnt=7, uf_cnt=1; macro off -> all 0.

Source files
------------

// File: rtl/proc_io_sched.sv
// proc_io_sched: sample-stream scheduler in front of a filter processor.
// Buffers input samples in a FIFO and holds the processor in reset until the
// FIFO is primed. It serves processor reads from the FIFO head and re-primes
// after an underflow. Decoded output enables become a tagged output stream.
// Optional statistics counters are built when IO_SCHED_STATS_EN is defined.
module proc_io_sched #(
  parameter int NUBITS = 32,
  parameter int NOUT   = 7,
  parameter int NBCH   = 3,
  parameter int FDEPTH = 16,
  parameter int NBFIFO = 4,
  parameter int PRIME  = 4,
  parameter int RSTLEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUBITS-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [NUBITS-1:0] proc_in,
  input  logic              proc_req_in,
  output logic              proc_rst,
  input  logic [NUBITS-1:0] proc_out,
  input  logic [NOUT-1:0]   proc_out_en,
  output logic [NUBITS-1:0] m_data,
  output logic [NBCH-1:0]   m_chan,
  output logic              m_valid,
  input  logic              err_clr,
  output logic              underflow,
  output logic              collision,
  output logic              running,
  output logic [15:0]       in_cnt,
  output logic [15:0]       out_cnt,
  output logic [15:0]       uf_cnt
);

  localparam int FCW = $clog2(RSTLEN + 1);

  typedef enum logic [1:0] {ST_PRIME, ST_RUN, ST_FAULT} state_t;

  state_t              state;
  logic [NUBITS-1:0]   mem [FDEPTH];
  logic [NBFIFO-1:0]   wr_ptr;
  logic [NBFIFO-1:0]   rd_ptr;
  logic [NBFIFO:0]     count;
  logic [FCW-1:0]      fcnt;
  logic                empty;
  logic                full;
  logic                push;
  logic                pop;
  logic                uf_evt;
  logic                any_en;
  logic                col_evt;

  // Index of the lowest asserted enable bit; the lowest channel wins on collision.
  function automatic logic [NBCH-1:0] lowest_idx(input logic [NOUT-1:0] en);
    logic [NBCH-1:0] idx;
    idx = '0;
    for (int i = NOUT - 1; i >= 0; i--) begin
      if (en[i]) idx = NBCH'(i);
    end
    return idx;
  endfunction

  // True when more than one enable bit is set.
  function automatic logic multi_hot(input logic [NOUT-1:0] en);
    return (en & (en - NOUT'(1))) != '0;
  endfunction

  // Saturating 16-bit increment for the statistics counters.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == (NBFIFO+1)'(FDEPTH));
  assign s_ready = !full && (state != ST_FAULT);
  assign push    = s_valid && s_ready;
  // A read on an empty FIFO is never satisfied by a same-cycle push.
  assign pop     = proc_req_in && (state == ST_RUN) && !empty;
  assign uf_evt  = proc_req_in && (state == ST_RUN) && empty;
  assign proc_in = empty ? '0 : mem[rd_ptr];
  assign any_en  = |proc_out_en;
  assign col_evt = multi_hot(proc_out_en);

  // FIFO storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  // FIFO pointers and occupancy; an underflow flushes everything at once.
  always_ff @(posedge clk) begin
    if (rst || uf_evt) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + NBFIFO'(1);
      if (pop)  rd_ptr <= rd_ptr + NBFIFO'(1);
      case ({push, pop})
        2'b10:   count <= count + (NBFIFO+1)'(1);
        2'b01:   count <= count - (NBFIFO+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Scheduler FSM: prime, run, fault-recovery with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_PRIME;
      proc_rst <= 1'b1;
      running  <= 1'b0;
      fcnt     <= '0;
    end else begin
      case (state)
        ST_PRIME: begin
          if (count >= (NBFIFO+1)'(PRIME)) begin
            state    <= ST_RUN;
            proc_rst <= 1'b0;
            running  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (uf_evt) begin
            state    <= ST_FAULT;
            proc_rst <= 1'b1;
            running  <= 1'b0;
            fcnt     <= '0;
          end
        end
        ST_FAULT: begin
          if (fcnt == FCW'(RSTLEN - 1)) begin
            state <= ST_PRIME;
          end else begin
            fcnt <= fcnt + FCW'(1);
          end
        end
        default: begin
          state    <= ST_PRIME;
          proc_rst <= 1'b1;
          running  <= 1'b0;
        end
      endcase
    end
  end

  // Output capture: one strobe per enable cycle, data and channel hold between strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_chan  <= '0;
    end else begin
      m_valid <= any_en;
      if (any_en) begin
        m_data <= proc_out;
        m_chan <= lowest_idx(proc_out_en);
      end
    end
  end

  // Sticky error flags; a new event in the same cycle beats the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      underflow <= 1'b0;
      collision <= 1'b0;
    end else begin
      underflow <= uf_evt  || (underflow && !err_clr);
      collision <= col_evt || (collision && !err_clr);
    end
  end

`ifdef IO_SCHED_STATS_EN
  // Saturating statistics, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_cnt  <= '0;
      out_cnt <= '0;
      uf_cnt  <= '0;
    end else begin
      if (push)   in_cnt  <= sat_inc(in_cnt);
      if (any_en) out_cnt <= sat_inc(out_cnt);
      if (uf_evt) uf_cnt  <= sat_inc(uf_cnt);
    end
  end
`else
  assign in_cnt  = '0;
  assign out_cnt = '0;
  assign uf_cnt  = '0;
`endif

endmodule

// File: tb/tb_proc_io_sched.sv
// Testbench for proc_io_sched: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_proc_io_sched;

  logic        clk;
  logic        rst;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] proc_in;
  logic        proc_req_in;
  logic        proc_rst;
  logic [31:0] proc_out;
  logic [6:0]  proc_out_en;
  logic [31:0] m_data;
  logic [2:0]  m_chan;
  logic        m_valid;
  logic        err_clr;
  logic        underflow;
  logic        collision;
  logic        running;
  logic [15:0] in_cnt;
  logic [15:0] out_cnt;
  logic [15:0] uf_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  proc_io_sched dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .proc_in(proc_in), .proc_req_in(proc_req_in), .proc_rst(proc_rst),
    .proc_out(proc_out), .proc_out_en(proc_out_en),
    .m_data(m_data), .m_chan(m_chan), .m_valid(m_valid),
    .err_clr(err_clr), .underflow(underflow), .collision(collision),
    .running(running), .in_cnt(in_cnt), .out_cnt(out_cnt), .uf_cnt(uf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] d);
    s_valid = 1'b1;
    s_data  = d;
    cyc(1);
    s_valid = 1'b0;
  endtask

  function automatic logic [15:0] sinc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Reference model: mode 0 = priming, 1 = running, 2 = fault recovery.
  logic [31:0] mq[$];
  int          mmode;
  int          mfl;
  bit          model_ok = 0;
  logic        e_rst, e_run, e_mv, e_uf, e_col;
  logic [31:0] e_md;
  logic [2:0]  e_mc;
  logic [15:0] e_in, e_out, e_ufc;
  int          m_osz, m_nb, m_lo;
  bit          m_rdy, m_psh, m_uf, m_pp;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        mq.delete();
        mmode = 0; mfl = 0;
        e_rst = 1'b1; e_run = 1'b0; e_mv = 1'b0; e_md = '0; e_mc = '0;
        e_uf = 1'b0; e_col = 1'b0; e_in = '0; e_out = '0; e_ufc = '0;
        model_ok = 1;
      end else if (model_ok) begin
        m_osz = mq.size();
        m_rdy = (m_osz < 16) && (mmode != 2);
        m_psh = s_valid && m_rdy;
        m_uf  = (mmode == 1) && proc_req_in && (m_osz == 0);
        m_pp  = (mmode == 1) && proc_req_in && (m_osz > 0);
        if (m_pp)  void'(mq.pop_front());
        if (m_psh) mq.push_back(s_data);
        if (mmode == 0) begin
          if (m_osz >= 4) mmode = 1;
        end else if (mmode == 1) begin
          if (m_uf) begin mmode = 2; mfl = 4; mq.delete(); end
        end else begin
          mfl--;
          if (mfl == 0) mmode = 0;
        end
        e_rst = (mmode != 1);
        e_run = (mmode == 1);
        m_nb = 0; m_lo = -1;
        for (int i = 0; i < 7; i++) begin
          if (proc_out_en[i]) begin
            m_nb++;
            if (m_lo < 0) m_lo = i;
          end
        end
        e_mv = (m_nb > 0);
        if (m_nb > 0) begin e_md = proc_out; e_mc = 3'(m_lo); end
`ifdef IO_SCHED_STATS_EN
        if (m_psh)    e_in  = sinc(e_in);
        if (m_nb > 0) e_out = sinc(e_out);
        if (m_uf)     e_ufc = sinc(e_ufc);
`endif
        if (m_uf) e_uf = 1'b1; else if (err_clr) e_uf = 1'b0;
        if (m_nb > 1) e_col = 1'b1; else if (err_clr) e_col = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (model_ok && !rst) begin
        chk("m_s_ready",  32'(s_ready),   32'((mq.size() < 16) && (mmode != 2)));
        chk("m_proc_in",  proc_in,        (mq.size() > 0) ? mq[0] : 32'h0);
        chk("m_proc_rst", 32'(proc_rst),  32'(e_rst));
        chk("m_running",  32'(running),   32'(e_run));
        chk("m_valid",    32'(m_valid),   32'(e_mv));
        chk("m_data",     m_data,         e_md);
        chk("m_chan",     32'(m_chan),    32'(e_mc));
        chk("m_underflow",32'(underflow), 32'(e_uf));
        chk("m_collision",32'(collision), 32'(e_col));
        chk("m_in_cnt",   32'(in_cnt),    32'(e_in));
        chk("m_out_cnt",  32'(out_cnt),   32'(e_out));
        chk("m_uf_cnt",   32'(uf_cnt),    32'(e_ufc));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int  np, rd, c, guard, lowc;
  bit  saw_full, acc;

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; proc_req_in = 1'b0;
    proc_out = '0; proc_out_en = '0; err_clr = 1'b0;
    cyc(2);
    rst = 1'b0;
    chk("rst_proc_rst", 32'(proc_rst), 32'd1);
    chk("rst_s_ready",  32'(s_ready),  32'd1);
    chk("rst_running",  32'(running),  32'd0);
    chk("rst_m_valid",  32'(m_valid),  32'd0);
    chk("rst_proc_in",  proc_in,       32'h0);
    chk("rst_uf",       32'(underflow),32'd0);

    // Prime with ramp samples 0x100..0x103
    for (int i = 0; i < 3; i++) push_one(32'h100 + 32'(i));
    cyc(2);
    chk("prime_hold3", 32'(proc_rst), 32'd1);
    push_one(32'h103);
    chk("prime_cnt_reached", 32'(proc_rst), 32'd1);
    cyc(1);
    chk("prime_release", 32'(proc_rst), 32'd0);
    chk("prime_running", 32'(running),  32'd1);
    chk("prime_head",    proc_in,       32'h100);

    // Steady stream: push at 1/2 rate, read at 1/4 rate
    np = 4; rd = 0; c = 0; saw_full = 0;
    while (np < 100 && c < 3000) begin
      s_valid     = (c % 2 == 0);
      s_data      = 32'h100 + 32'(np);
      proc_req_in = (c % 4 == 0);
      if (!s_ready) saw_full = 1;
      if (proc_req_in) begin
        chk("stream_rd", proc_in, 32'h100 + 32'(rd));
        rd++;
      end
      acc = s_valid && s_ready;
      cyc(1);
      if (acc) np++;
      c++;
    end
    s_valid = 1'b0; proc_req_in = 1'b0;
    chk("stream_all_pushed", 32'(np), 32'd100);
    chk("stream_saw_full",   32'(saw_full), 32'd1);

    // Drain remaining samples in order
    guard = 0;
    while (rd < np && guard < 200) begin
      proc_req_in = 1'b1;
      chk("drain_rd", proc_in, 32'h100 + 32'(rd));
      rd++; guard++;
      cyc(1);
    end
    proc_req_in = 1'b0;
    chk("drain_empty", proc_in, 32'h0);

    // Simultaneous push and pop at occupancy 5
    for (int i = 0; i < 5; i++) push_one(32'h200 + 32'(i));
    s_valid = 1'b1; s_data = 32'h205; proc_req_in = 1'b1;
    chk("pp_head", proc_in, 32'h200);
    cyc(1);
    s_valid = 1'b0; proc_req_in = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      proc_req_in = 1'b1;
      chk("pp_rd", proc_in, 32'h200 + 32'(i));
      cyc(1);
    end
    proc_req_in = 1'b0;
    chk("pp_empty", proc_in, 32'h0);
    chk("pp_no_uf", 32'(underflow), 32'd0);

    // Underflow on empty FIFO in RUN
    proc_req_in = 1'b1;
    cyc(1);
    proc_req_in = 1'b0;
    chk("uf_flag",    32'(underflow), 32'd1);
    chk("uf_proc_rst",32'(proc_rst),  32'd1);
    chk("uf_running", 32'(running),   32'd0);
    lowc = 0;
    for (int i = 0; i < 10; i++) begin
      if (!s_ready) lowc++;
      cyc(1);
    end
    chk("uf_fault_len", 32'(lowc), 32'd4);
    chk("uf_prime_rst", 32'(proc_rst), 32'd1);
    chk("uf_prime_in",  proc_in,       32'h0);
    chk("uf_prime_rdy", 32'(s_ready),  32'd1);

    // Re-prime, clear, then push into empty with a same-cycle read
    for (int i = 0; i < 4; i++) push_one(32'h300 + 32'(i));
    cyc(1);
    chk("reprime_run", 32'(running), 32'd1);
    for (int i = 0; i < 4; i++) begin
      proc_req_in = 1'b1;
      chk("reprime_rd", proc_in, 32'h300 + 32'(i));
      cyc(1);
    end
    proc_req_in = 1'b0;
    err_clr = 1'b1; cyc(1); err_clr = 1'b0;
    chk("uf_cleared", 32'(underflow), 32'd0);
    s_valid = 1'b1; s_data = 32'h304; proc_req_in = 1'b1;
    cyc(1);
    s_valid = 1'b0; proc_req_in = 1'b0;
    chk("uf_push_empty", 32'(underflow), 32'd1);
    chk("uf_push_rdy",   32'(s_ready),   32'd0);
    cyc(5);
    chk("uf_push_flushed", proc_in, 32'h0);

    // Output tagging and collision
    proc_out_en = 7'b0000100; proc_out = 32'h3F800000;
    cyc(1);
    proc_out_en = '0; proc_out = '0;
    chk("tag_valid", 32'(m_valid), 32'd1);
    chk("tag_chan",  32'(m_chan),  32'd2);
    chk("tag_data",  m_data,       32'h3F800000);
    chk("tag_nocol", 32'(collision), 32'd0);
    cyc(1);
    chk("tag_once",  32'(m_valid), 32'd0);
    chk("tag_hold",  m_data,       32'h3F800000);
    proc_out_en = 7'b0010010; proc_out = 32'h12345678;
    cyc(1);
    proc_out_en = '0;
    chk("col_chan", 32'(m_chan),    32'd1);
    chk("col_data", m_data,         32'h12345678);
    chk("col_flag", 32'(collision), 32'd1);
    err_clr = 1'b1; cyc(1); err_clr = 1'b0;
    chk("col_clear", 32'(collision), 32'd0);
    chk("uf_clear2", 32'(underflow), 32'd0);

    // Mid-operation reset discards FIFO, then statistics scenario
    push_one(32'h400);
    push_one(32'h401);
    rst = 1'b1; cyc(1); rst = 1'b0;
    chk("mrst_in",  proc_in,         32'h0);
    chk("mrst_rdy", 32'(s_ready),    32'd1);
    chk("mrst_rst", 32'(proc_rst),   32'd1);
    chk("mrst_cnt", 32'(in_cnt),     32'd0);
    for (int i = 0; i < 4; i++) push_one(32'h500 + 32'(i));
    cyc(1);
    chk("st_run", 32'(running), 32'd1);
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1; s_data = 32'h504 + 32'(i); proc_req_in = 1'b1;
      cyc(1);
    end
    s_valid = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1);
    chk("st_no_uf", 32'(underflow), 32'd0);
    cyc(1);
    proc_req_in = 1'b0;
    for (int i = 0; i < 7; i++) begin
      proc_out_en = 7'(1 << i); proc_out = 32'(i);
      cyc(1);
    end
    proc_out_en = '0;
    cyc(6);
    chk("st_uf_flag", 32'(underflow), 32'd1);
`ifdef IO_SCHED_STATS_EN
    chk("st_in_cnt",  32'(in_cnt),  32'd20);
    chk("st_out_cnt", 32'(out_cnt), 32'd7);
    chk("st_uf_cnt",  32'(uf_cnt),  32'd1);
`else
    chk("st_in_cnt",  32'(in_cnt),  32'd0);
    chk("st_out_cnt", 32'(out_cnt), 32'd0);
    chk("st_uf_cnt",  32'(uf_cnt),  32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
